// File: rtl/ram_scan_stats_pkg.sv
// Shared types and default widths for the RAM scan statistics block.
package ram_scan_pkg;

   localparam int SCAN_ADDR_W = 9;
   localparam int SCAN_DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } scan_state_e;

endpackage

// File: rtl/ram_scan_stats_if.sv
// Handshake, RAM port and result bus between the scanner and its surroundings.
interface ram_scan_stats_if
   import ram_scan_pkg::*;
#(
   parameter int ADDR_W = SCAN_ADDR_W,
   parameter int DATA_W = SCAN_DATA_W
);
   logic              START_I;
   logic [DATA_W-1:0] MATCH_VALUE_I;
   logic [ADDR_W-1:0] RAM_ADDRESS_O;
   logic [DATA_W-1:0] RAM_READ_DATA_I;
   logic              BUSY_O;
   logic              DONE_O;
   logic [DATA_W-1:0] MAX_VALUE_O;
   logic [ADDR_W-1:0] MAX_ADDRESS_O;
   logic [ADDR_W:0]   MATCH_COUNT_O;

   // master: the surroundings (control, RAM, display); slave: the scanner
   modport master (
      output START_I, MATCH_VALUE_I, RAM_READ_DATA_I,
      input  RAM_ADDRESS_O, BUSY_O, DONE_O, MAX_VALUE_O, MAX_ADDRESS_O, MATCH_COUNT_O
   );

   modport slave (
      input  START_I, MATCH_VALUE_I, RAM_READ_DATA_I,
      output RAM_ADDRESS_O, BUSY_O, DONE_O, MAX_VALUE_O, MAX_ADDRESS_O, MATCH_COUNT_O
   );
endinterface

// File: rtl/ram_scan_stats_valid_delay_line.sv
// Shift register carrying {valid, address} alongside the RAM read latency.
module valid_delay_line #(
   parameter int ADDR_W = 9,
   parameter int STAGES = 1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr
);
   logic              r_valid [STAGES];
   logic [ADDR_W-1:0] r_addr  [STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  r_valid[0] <= 1'b0;
                  r_addr[0]  <= '0;
               end else begin
                  r_valid[0] <= i_valid;
                  r_addr[0]  <= i_addr;
               end
            end
         end else begin : g_tail
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  r_valid[gi] <= 1'b0;
                  r_addr[gi]  <= '0;
               end else begin
                  r_valid[gi] <= r_valid[gi-1];
                  r_addr[gi]  <= r_addr[gi-1];
               end
            end
         end
      end
   endgenerate

   assign o_valid = r_valid[STAGES-1];
   assign o_addr  = r_addr[STAGES-1];
endmodule

// File: rtl/ram_scan_stats.sv
// Sweeps a synchronous-read RAM and publishes max value, its lowest address
// and the count of words equal to a compare value latched at start.
module ram_scan_stats
   import ram_scan_pkg::*;
#(
   parameter int ADDR_W = SCAN_ADDR_W,
   parameter int DATA_W = SCAN_DATA_W,
   parameter int RD_LAT = 1
)(
   input  logic             CLOCK_50_I,
   input  logic             RESET_I,
   ram_scan_stats_if.slave  bus
);
   scan_state_e       r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_max_out;
   logic [ADDR_W-1:0] r_max_addr_out;
   logic [ADDR_W:0]   r_count_out;
   logic [DATA_W-1:0] r_match_val;
   logic [DATA_W-1:0] r_run_max;
   logic [ADDR_W-1:0] r_run_addr;
   logic [ADDR_W:0]   r_run_count;
   logic              r_have_max;
   logic              r_publish;

   logic              w_pipe_valid;
   logic [ADDR_W-1:0] w_pipe_addr;
   logic              w_accept;
   logic              w_push;
   logic              w_last;
   logic              w_take_max;
   logic              w_is_match;

   valid_delay_line #(
      .ADDR_W (ADDR_W),
      .STAGES (RD_LAT)
   ) u_valid_delay (
      .i_clk   (CLOCK_50_I),
      .i_rst   (RESET_I),
      .i_valid (w_push),
      .i_addr  (r_addr),
      .o_valid (w_pipe_valid),
      .o_addr  (w_pipe_addr)
   );

   always_comb begin
      w_accept   = bus.START_I && ((r_state == S_IDLE) || (r_state == S_DONE));
      w_push     = (r_state == S_SCAN);
      w_last     = w_pipe_valid && (w_pipe_addr == '1);
      // first valid word seeds the running max so an all-zero RAM reports address 0
      w_take_max = w_pipe_valid && (!r_have_max || (bus.RAM_READ_DATA_I > r_run_max));
      w_is_match = w_pipe_valid && (bus.RAM_READ_DATA_I == r_match_val);
   end

   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         r_state        <= S_IDLE;
         r_addr         <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_max_out      <= '0;
         r_max_addr_out <= '0;
         r_count_out    <= '0;
         r_match_val    <= '0;
         r_run_max      <= '0;
         r_run_addr     <= '0;
         r_run_count    <= '0;
         r_have_max     <= 1'b0;
         r_publish      <= 1'b0;
      end else begin
         r_publish <= w_last;

         if (w_take_max) begin
            r_run_max  <= bus.RAM_READ_DATA_I;
            r_run_addr <= w_pipe_addr;
            r_have_max <= 1'b1;
         end
         if (w_is_match) begin
            r_run_count <= r_run_count + 1'b1;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_state     <= S_SCAN;
                  r_addr      <= '0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_match_val <= bus.MATCH_VALUE_I;
                  r_run_max   <= '0;
                  r_run_addr  <= '0;
                  r_run_count <= '0;
                  r_have_max  <= 1'b0;
               end
            end
            S_SCAN: begin
               // wraps to 0 after the last address; that value is never pushed
               r_addr <= r_addr + 1'b1;
               if (r_addr == '1) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_publish) begin
                  r_state        <= S_DONE;
                  r_busy         <= 1'b0;
                  r_done         <= 1'b1;
                  r_max_out      <= r_run_max;
                  r_max_addr_out <= r_run_addr;
                  r_count_out    <= r_run_count;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.RAM_ADDRESS_O = r_addr;
   assign bus.BUSY_O        = r_busy;
   assign bus.DONE_O        = r_done;
   assign bus.MAX_VALUE_O   = r_max_out;
   assign bus.MAX_ADDRESS_O = r_max_addr_out;
   assign bus.MATCH_COUNT_O = r_count_out;
endmodule

// File: tb/tb_ram_scan_stats.sv
// Directed bench: two scanners (read latency 1 and 2) share one RAM image.
module tb_ram_scan_stats;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;

   logic [7:0] mem [512];
   logic [7:0] r_lat2_stage;
   logic [7:0] exp_max;
   logic [8:0] exp_addr;
   logic [9:0] exp_cnt;

   always #10 clk = ~clk;

   ram_scan_stats_if #(.ADDR_W(9), .DATA_W(8)) bus1 ();
   ram_scan_stats_if #(.ADDR_W(9), .DATA_W(8)) bus2 ();

   ram_scan_stats #(.ADDR_W(9), .DATA_W(8), .RD_LAT(1)) u_dut1 (
      .CLOCK_50_I (clk),
      .RESET_I    (rst),
      .bus        (bus1)
   );

   ram_scan_stats #(.ADDR_W(9), .DATA_W(8), .RD_LAT(2)) u_dut2 (
      .CLOCK_50_I (clk),
      .RESET_I    (rst),
      .bus        (bus2)
   );

   // RAM models: one and two registered read stages
   always @(posedge clk) begin
      bus1.RAM_READ_DATA_I <= mem[bus1.RAM_ADDRESS_O];
      r_lat2_stage         <= mem[bus2.RAM_ADDRESS_O];
      bus2.RAM_READ_DATA_I <= r_lat2_stage;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic drive(input logic st, input logic [7:0] mv);
      bus1.START_I       = st;
      bus2.START_I       = st;
      bus1.MATCH_VALUE_I = mv;
      bus2.MATCH_VALUE_I = mv;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start pulse, then 530 edges; records first DONE edge of each DUT, BUSY
   // edges of dut1 before DONE, and any published-output change before DONE.
   task automatic run_scan(input logic [7:0] mv, input int repulse_at,
                           output int d1, output int d2, output int busy_cnt, output int hold_bad);
      d1 = 0; d2 = 0; busy_cnt = 0; hold_bad = 0;
      drive(1'b1, mv);
      step();
      drive(1'b0, mv);
      check("start_busy", bus1.BUSY_O, 1);
      check("start_done", bus1.DONE_O, 0);
      check("start_addr", bus1.RAM_ADDRESS_O, 0);
      for (int k = 1; k <= 530; k++) begin
         step();
         if (d1 == 0) begin
            if (bus1.BUSY_O) busy_cnt++;
            if (bus1.DONE_O) d1 = k;
            else if (bus1.MAX_VALUE_O !== exp_max || bus1.MAX_ADDRESS_O !== exp_addr ||
                     bus1.MATCH_COUNT_O !== exp_cnt) hold_bad++;
         end
         if (d2 == 0 && bus2.DONE_O) d2 = k;
         if (k == repulse_at) drive(1'b1, 8'hFF);
         else if (k == repulse_at + 1) drive(1'b0, 8'hFF);
      end
   endtask

   task automatic check_res(input string tag, input logic [7:0] mx, input logic [8:0] ma, input logic [9:0] mc);
      check({tag, "_max"},  bus1.MAX_VALUE_O, mx);
      check({tag, "_addr"}, bus1.MAX_ADDRESS_O, ma);
      check({tag, "_cnt"},  bus1.MATCH_COUNT_O, mc);
      exp_max = mx; exp_addr = ma; exp_cnt = mc;
   endtask

   initial begin
      int d1, d2, bc, hb;
      drive(1'b0, 8'h00);
      exp_max = 0; exp_addr = 0; exp_cnt = 0;
      for (int i = 0; i < 512; i++) mem[i] = i[7:0];
      #1;
      check("rst_busy", bus1.BUSY_O, 0);
      check("rst_done", bus1.DONE_O, 0);
      check("rst_cnt",  bus1.MATCH_COUNT_O, 0);
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();

      // identity sweep, both latencies
      run_scan(8'h10, -10, d1, d2, bc, hb);
      check("id_done_edge", d1, 514);
      check("id_busy_edges", bc, 513);
      check("id_hold", hb, 0);
      check("id_busy_after", bus1.BUSY_O, 0);
      check("lat2_done_edge", d2, 515);
      check("lat2_max",  bus2.MAX_VALUE_O, 8'hFF);
      check("lat2_addr", bus2.MAX_ADDRESS_O, 255);
      check("lat2_cnt",  bus2.MATCH_COUNT_O, 2);
      check_res("id", 8'hFF, 9'd255, 10'd2);

      // constant zero RAM: full-depth count
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      run_scan(8'h00, -10, d1, d2, bc, hb);
      check("zero_done_edge", d1, 514);
      check("zero_hold", hb, 0);
      check_res("zero", 8'h00, 9'd0, 10'd512);

      // late single peak
      for (int i = 0; i < 512; i++) mem[i] = 8'h05;
      mem[511] = 8'h80;
      run_scan(8'h05, -10, d1, d2, bc, hb);
      check("peak_done_edge", d1, 514);
      check("peak_hold", hb, 0);
      check_res("peak", 8'h80, 9'd511, 10'd511);

      // reset mid-scan
      for (int i = 0; i < 512; i++) mem[i] = i[7:0];
      drive(1'b1, 8'h10);
      step();
      drive(1'b0, 8'h10);
      repeat (199) step();
      #3 rst = 1'b1;
      #1;
      check("mid_rst_addr",  bus1.RAM_ADDRESS_O, 0);
      check("mid_rst_busy",  bus1.BUSY_O, 0);
      check("mid_rst_done",  bus1.DONE_O, 0);
      check("mid_rst_max",   bus1.MAX_VALUE_O, 0);
      check("mid_rst_maddr", bus1.MAX_ADDRESS_O, 0);
      check("mid_rst_cnt",   bus1.MATCH_COUNT_O, 0);
      check("mid_rst_state", u_dut1.r_state, 0);
      check("mid_rst_busy2", bus2.BUSY_O, 0);
      repeat (3) step();
      rst = 1'b0;
      d1 = 0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (bus1.DONE_O || bus1.BUSY_O) d1++;
      end
      check("post_rst_quiet", d1, 0);
      exp_max = 0; exp_addr = 0; exp_cnt = 0;
      run_scan(8'h10, -10, d1, d2, bc, hb);
      check("rerun_done_edge", d1, 514);
      check("rerun_hold", hb, 0);
      check_res("rerun", 8'hFF, 9'd255, 10'd2);

      // start with a new compare value while busy is ignored
      run_scan(8'h10, 100, d1, d2, bc, hb);
      check("ign_done_edge", d1, 514);
      check("ign_busy_edges", bc, 513);
      check_res("ign", 8'hFF, 9'd255, 10'd2);

      // rescan after RAM rewrite: old results hold until new DONE
      for (int i = 0; i < 512; i++) mem[i] = (i < 256) ? 8'h40 : i[7:0];
      run_scan(8'h40, -10, d1, d2, bc, hb);
      check("new_done_edge", d1, 514);
      check("new_hold", hb, 0);
      check_res("new", 8'hFF, 9'd511, 10'd257);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
